fp_accumulator: RTL and testbench
=================================

FP_ACCUMULATOR -- requirements
Module: fp_accumulator

Interface
REQ-001 SHALL have parameter N, default 32, meaning the IEEE-754 single-precision word width; only 32 is supported.
REQ-002 SHALL have parameter LEN, default 4, meaning the number of terms summed per result; legal range is 1..256.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 SHALL have port clr, input, 1 bit: synchronous abort of the current sum.
REQ-006 SHALL have port in_valid, input, 1 bit: the input term is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: the block can accept an input term.
REQ-008 SHALL have port in_data, input, N bits: the input float term.
REQ-009 SHALL have port out_valid, output, 1 bit: the sum is valid.
REQ-010 SHALL have port out_ready, input, 1 bit: downstream accepts the sum.
REQ-011 SHALL have port out_data, output, N bits: the float sum.
REQ-012 SHALL have port add_a, output, N bits: operand A to the external combinational fp_adder.
REQ-013 SHALL have port add_b, output, N bits: operand B to the external combinational fp_adder.
REQ-014 SHALL have port add_result, input, N bits: the fp_adder sum, valid in the same cycle as add_a and add_b.

Function
REQ-015 SHALL implement a two-state FSM with states ACCUM and DONE.
REQ-016 SHALL hold a registered N-bit accumulator acc and a term counter cnt of width clog2(LEN)+1.
REQ-017 SHALL drive in_ready=1 only in ACCUM; out_valid=1 only in DONE.
REQ-018 SHALL treat an input as accepted when in_valid && in_ready at a rising edge.
REQ-019 SHALL load acc directly from in_data on the first accepted term (cnt==0), bypassing the adder, because fp_adder does not represent zero.
REQ-020 SHALL load acc from add_result on each later accepted term, with add_a=acc and add_b=in_data driven combinationally.
REQ-021 SHALL drive add_a=acc and add_b=in_data in all states.
REQ-022 SHALL increment cnt on each accepted term.
REQ-023 SHALL move from ACCUM to DONE on acceptance of term LEN (cnt==LEN-1).
REQ-024 SHALL assert out_valid in the cycle after the last term is accepted (latency 1 cycle).
REQ-025 SHALL keep out_data and out_valid stable in DONE until out_ready=1.
REQ-026 SHALL, on out_ready && out_valid, return to ACCUM with cnt=0; the next term is acceptable in the following cycle (no same-cycle overlap).
REQ-027 SHALL hold acc and cnt unchanged in ACCUM when in_valid=0.
REQ-028 SHALL with LEN=1 output the single term unmodified, subject to REQ-035.
REQ-029 SHALL give clr priority over every handshake: the next state is ACCUM, cnt=0, acc=0, out_valid=0, and any same-cycle input term is dropped.
REQ-030 SHALL leave out_data undefined-free: it always equals the registered output word.

Reset
REQ-031 SHALL, on rst_n=0, asynchronously set state=ACCUM, cnt=0, acc=0, out_data=0 and out_valid=0.
REQ-032 SHALL drive in_ready=1 one cycle after rst_n deasserts; in_ready stays 0 while rst_n=0.
REQ-033 SHALL, on reset mid-sum or in DONE, discard the partial or pending result with no output emitted.

Configuration
REQ-034 SHALL use macro FP_ACC_RELU_EN to enable ReLU on the output.
REQ-035 SHALL, with FP_ACC_RELU_EN defined, drive out_data=0x00000000 when the final acc sign bit is 1, and acc otherwise.
REQ-036 SHALL, without FP_ACC_RELU_EN defined, drive out_data=acc unconditionally; no ReLU logic is present.

Verification
REQ-037 SHALL cover: LEN=4, inputs 0x3F800000, 0x40000000, 0x40400000, 0x40800000 back-to-back with out_ready=1 -> out_data=0x41200000 (10.0), out_valid high for 1 cycle, one cycle after the 4th accept.
REQ-038 SHALL cover: same inputs with gaps in in_valid and out_ready=0 for 5 cycles -> out_data 0x41200000 held, in_ready=0 throughout DONE.
REQ-039 SHALL cover: inputs 0xBF800000, 0xC0000000, 0xC0400000, 0xC0800000 -> out_data=0xC1200000 without the macro, and 0x00000000 with FP_ACC_RELU_EN.
REQ-040 SHALL cover: two terms accepted, then clr=1 with in_valid=1 -> cnt=0 and the term is dropped; then four 1.0 terms -> out_data=0x40800000.
REQ-041 SHALL cover: rst_n pulsed low asynchronously after 3 terms -> out_valid=0 and out_data=0 immediately; the next 4 terms sum correctly.
REQ-042 SHALL cover: LEN=1, input 0x40A00000 -> out_data=0x40A00000 and the adder result is unused.

Source files
------------

// File: rtl/fp_accumulator.sv
// Streaming float accumulator: sums LEN terms through an external combinational fp_adder.
// Optional ReLU on the result when FP_ACC_RELU_EN is defined.
module fp_accumulator #(
  parameter int N   = 32,
  parameter int LEN = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data,
  output logic [N-1:0] add_a,
  output logic [N-1:0] add_b,
  input  logic [N-1:0] add_result
);

  localparam int CW = $clog2(LEN) + 1;
  localparam logic [0:0] ACCUM = 1'b0;
  localparam logic [0:0] DONE  = 1'b1;

  logic [0:0]    state;
  logic [N-1:0]  acc;
  logic [CW-1:0] cnt;
  logic [N-1:0]  out_word;
  logic          started;
  logic          accept;
  logic          last;
  logic [N-1:0]  sum_next;
  logic [N-1:0]  result;

  // started keeps in_ready low during reset and for the first edge after release
  assign in_ready  = started && (state == ACCUM);
  assign out_valid = (state == DONE);
  assign out_data  = out_word;
  assign add_a     = acc;
  assign add_b     = in_data;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt == CW'(LEN - 1));

  // The adder cannot produce zero-based sums, so the first term bypasses it
  assign sum_next = (cnt == '0) ? in_data : add_result;

`ifdef FP_ACC_RELU_EN
  assign result = sum_next[N-1] ? '0 : sum_next;
`else
  assign result = sum_next;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ACCUM;
      acc      <= '0;
      cnt      <= '0;
      out_word <= '0;
      started  <= 1'b0;
    end else begin
      started <= 1'b1;
      if (clr) begin
        state <= ACCUM;
        acc   <= '0;
        cnt   <= '0;
      end else begin
        case (state)
          ACCUM: begin
            if (accept) begin
              acc <= sum_next;
              cnt <= cnt + 1'b1;
              if (last) begin
                state    <= DONE;
                out_word <= result;
              end
            end
          end
          DONE: begin
            if (out_ready) begin
              state <= ACCUM;
              cnt   <= '0;
            end
          end
          default: state <= ACCUM;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fp_accumulator.sv
// Self-checking bench for fp_accumulator: LEN=4 and LEN=1 instances, behavioural adder
// and integer-arithmetic reference model.
module tb_fp_accumulator;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic [31:0] add_result;

  logic        in_valid1;
  logic        in_ready1;
  logic [31:0] in_data1;
  logic        out_valid1;
  logic        out_ready1;
  logic [31:0] out_data1;
  logic [31:0] add_a1;
  logic [31:0] add_b1;
  logic [31:0] add_result1;

  int checks = 0;
  int passes = 0;

  fp_accumulator #(.N(32), .LEN(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .add_a(add_a), .add_b(add_b), .add_result(add_result)
  );

  fp_accumulator #(.N(32), .LEN(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid1), .in_ready(in_ready1), .in_data(in_data1),
    .out_valid(out_valid1), .out_ready(out_ready1), .out_data(out_data1),
    .add_a(add_a1), .add_b(add_b1), .add_result(add_result1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic real fp_to_real(input logic [31:0] b);
    real v;
    int  e;
    e = int'(b[30:23]);
    if (e == 0) return 0.0;
    v = (1.0 + real'(b[22:0]) / 8388608.0) * (2.0 ** (e - 127));
    return b[31] ? -v : v;
  endfunction

  function automatic logic [31:0] real_to_fp(input real r);
    real a;
    int  e;
    int  m;
    logic [7:0]  eb;
    logic [22:0] mb;
    if (r == 0.0) return 32'h0;
    a = (r < 0.0) ? -r : r;
    e = 0;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0)  begin a = a * 2.0; e--; end
    m  = int'((a - 1.0) * 8388608.0);
    eb = 8'(e + 127);
    mb = 23'(m);
    return {(r < 0.0), eb, mb};
  endfunction

  // Exact single-precision encoding of a small integer
  function automatic logic [31:0] int_to_fp(input int v);
    int mag;
    int p;
    logic [31:0] w;
    if (v == 0) return 32'h0;
    mag = (v < 0) ? -v : v;
    p = 0;
    for (int i = 0; i < 31; i++) if (mag >= (1 << i)) p = i;
    w = 32'(mag) << (23 - p);
    return {(v < 0), 8'(127 + p), w[22:0]};
  endfunction

  function automatic logic [31:0] apply_relu(input logic [31:0] w);
`ifdef FP_ACC_RELU_EN
    return w[31] ? 32'h0 : w;
`else
    return w;
`endif
  endfunction

  always_comb add_result = real_to_fp(fp_to_real(add_a) + fp_to_real(add_b));
  assign add_result1 = 32'hDEADBEEF;

  // Offer one term after an idle gap; returns at the negedge following acceptance
  task automatic send(input logic [31:0] d, input int gap);
    int waited;
    for (int i = 0; i < gap; i++) begin
      in_valid = 1'b0;
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_data  = d;
    waited   = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_data = 32'h0; out_ready = 1'b1;
    in_valid1 = 1'b0; in_data1 = 32'h0; out_ready1 = 1'b1;
    #2;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || out_data !== 32'h0)
      $display("FAIL reset_state: in_ready=%0b out_valid=%0b out_data=%h required 0 0 00000000",
               in_ready, out_valid, out_data);
    else passes++;
    rst_n = 1'b1;
    checks++;
    if (in_ready !== 1'b0) $display("FAIL ready_at_release: in_ready=%0b required 0", in_ready);
    else passes++;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) $display("FAIL ready_after_release: in_ready=%0b required 1", in_ready);
    else passes++;
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    send(32'h40400000, 0);
    checks++;
    if (out_valid !== 1'b0) $display("FAIL b2b_early_valid: out_valid=%0b required 0", out_valid);
    else passes++;
    send(32'h40800000, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h41200000)
      $display("FAIL b2b_result: out_valid=%0b out_data=%h required 1 41200000", out_valid, out_data);
    else passes++;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL b2b_one_cycle: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_gaps_stall;
    out_ready = 1'b0;
    send(32'h3F800000, 2);
    send(32'h40000000, 1);
    send(32'h40400000, 3);
    send(32'h40800000, 1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== 32'h41200000 || in_ready !== 1'b0)
        $display("FAIL stall_hold: cycle=%0d out_valid=%0b out_data=%h in_ready=%0b required 1 41200000 0",
                 i, out_valid, out_data, in_ready);
      else passes++;
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL stall_release: out_valid=%0b in_ready=%0b required 0 1", out_valid, in_ready);
    else passes++;
  endtask

  task automatic test_negative;
    logic [31:0] exp_w;
    exp_w = apply_relu(32'hC1200000);
    send(32'hBF800000, 0);
    send(32'hC0000000, 0);
    send(32'hC0400000, 0);
    send(32'hC0800000, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_w)
      $display("FAIL negative_sum: out_valid=%0b out_data=%h required 1 %h", out_valid, out_data, exp_w);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_clr;
    send(32'h3F800000, 0);
    send(32'h40000000, 0);
    clr = 1'b1; in_valid = 1'b1; in_data = 32'h40A00000;
    @(negedge clk);
    clr = 1'b0; in_valid = 1'b0;
    checks++;
    if (dut4.cnt !== '0 || out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL clr_abort: cnt=%0d out_valid=%0b in_ready=%0b required 0 0 1",
               dut4.cnt, out_valid, in_ready);
    else passes++;
    for (int i = 0; i < 4; i++) send(32'h3F800000, 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 32'h40800000)
      $display("FAIL clr_resume: out_valid=%0b out_data=%h required 1 40800000", out_valid, out_data);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_async_reset;
    logic [31:0] exp_w;
    send(32'h40400000, 0);
    send(32'h40400000, 0);
    send(32'h40400000, 0);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || in_ready !== 1'b0)
      $display("FAIL async_reset: out_valid=%0b out_data=%h in_ready=%0b required 0 00000000 0",
               out_valid, out_data, in_ready);
    else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_w = apply_relu(int_to_fp(3 + 4 + 5 + 6));
    send(int_to_fp(3), 0);
    send(int_to_fp(4), 0);
    send(int_to_fp(5), 0);
    send(int_to_fp(6), 0);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_w)
      $display("FAIL post_reset_sum: out_valid=%0b out_data=%h required 1 %h", out_valid, out_data, exp_w);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_len1;
    logic [31:0] terms [2];
    logic [31:0] exp_w;
    terms[0] = 32'h40A00000;
    terms[1] = 32'hC0400000;
    for (int t = 0; t < 2; t++) begin
      exp_w = apply_relu(terms[t]);
      in_valid1 = 1'b1; in_data1 = terms[t];
      checks++;
      if (in_ready1 !== 1'b1) $display("FAIL len1_ready: in_ready=%0b required 1", in_ready1);
      else passes++;
      @(negedge clk);
      in_valid1 = 1'b0;
      checks++;
      if (out_valid1 !== 1'b1 || out_data1 !== exp_w)
        $display("FAIL len1_result: term=%0d out_valid=%0b out_data=%h required 1 %h",
                 t, out_valid1, out_data1, exp_w);
      else passes++;
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int vals [4];
    int sum;
    logic [31:0] exp_w;
    for (int r = 0; r < 20; r++) begin
      out_ready = 1'b0;
      sum = 0;
      for (int k = 0; k < 4; k++) begin
        vals[k] = int'($urandom_range(0, 31)) - 16;
        if (vals[k] >= 0) vals[k] = vals[k] + 1;
        sum += vals[k];
      end
      exp_w = apply_relu(int_to_fp(sum));
      for (int k = 0; k < 4; k++) send(int_to_fp(vals[k]), int'($urandom_range(0, 2)));
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_w)
        $display("FAIL random_sum: run=%0d terms=%0d,%0d,%0d,%0d out_valid=%0b out_data=%h required 1 %h",
                 r, vals[0], vals[1], vals[2], vals[3], out_valid, out_data, exp_w);
      else passes++;
      repeat ($urandom_range(0, 2)) @(negedge clk);
      out_ready = 1'b1;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_gaps_stall();
    test_negative();
    test_clr();
    test_async_reset();
    test_len1();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
